// File: rtl/led_blinker_bank.sv
// ============================================================================
// Module   : led_blinker_bank
// Brief    : Bank of NCH LED channels (OFF/ON/BLINK/ONESHOT) sharing one tick.
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_blinker_bank #(
  parameter int NCH      = 4,
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [2*NCH-1:0]       mode,
  input  logic [CNT_W*NCH-1:0]   half_period,
  input  logic [NCH-1:0]         trig,
  output logic [NCH-1:0]         led,
  output logic [NCH-1:0]         busy,
  output logic                   tick
);

  localparam int                    c_pcnt_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_pcnt_w-1:0]   c_pcnt_last = c_pcnt_w'(TICK_DIV - 1);

  localparam logic [1:0] c_mode_off   = 2'b00;
  localparam logic [1:0] c_mode_on    = 2'b01;
  localparam logic [1:0] c_mode_blink = 2'b10;

  typedef enum logic [0:0] {
    OS_IDLE   = 1'b0,
    OS_ACTIVE = 1'b1
  } os_state_t;

  logic [c_pcnt_w-1:0] r_pcnt;
  logic                r_tick;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_pcnt == c_pcnt_last);
      r_pcnt <= (r_pcnt == c_pcnt_last) ? '0 : r_pcnt + 1'b1;
    end
  end

  assign tick = r_tick;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]       w_mode;
    logic [1:0]       r_prev_mode;
    logic [CNT_W-1:0] w_hp;
    logic [CNT_W-1:0] w_hp_m1;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_led;
    logic             w_led_nxt;
    logic             w_entry;
    logic             w_at_end;
    os_state_t        r_state;
    os_state_t        w_state_nxt;

    assign w_mode   = mode[2*i +: 2];
    assign w_hp     = half_period[CNT_W*i +: CNT_W];
    // A half-period of 0 behaves as 1, so the terminal count is 0 in both cases.
    assign w_hp_m1  = (w_hp == '0) ? '0 : w_hp - 1'b1;
    assign w_entry  = (w_mode != r_prev_mode);
    assign w_at_end = (r_cnt >= w_hp_m1);

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        r_prev_mode <= c_mode_off;
        r_cnt       <= '0;
        r_led       <= 1'b0;
        r_state     <= OS_IDLE;
      end else begin
        r_prev_mode <= w_mode;
        r_cnt       <= w_cnt_nxt;
        r_led       <= w_led_nxt;
        r_state     <= w_state_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_led_nxt   = r_led;
      case (w_mode)
        c_mode_off: begin
          w_state_nxt = OS_IDLE;
          w_cnt_nxt   = '0;
          w_led_nxt   = 1'b0;
        end
        c_mode_on: begin
          w_state_nxt = OS_IDLE;
          w_cnt_nxt   = '0;
          w_led_nxt   = 1'b1;
        end
        c_mode_blink: begin
          w_state_nxt = OS_IDLE;
          if (w_entry) begin
            w_cnt_nxt = '0;
            w_led_nxt = 1'b1;
          end else if (r_tick) begin
            if (w_at_end) begin
              w_cnt_nxt = '0;
              w_led_nxt = ~r_led;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        default: begin
          // Trigger on the entry cycle is deliberately dropped.
          if (w_entry) begin
            w_state_nxt = OS_IDLE;
            w_cnt_nxt   = '0;
            w_led_nxt   = 1'b0;
          end else begin
            case (r_state)
              OS_IDLE: begin
                if (trig[i]) begin
                  w_state_nxt = OS_ACTIVE;
                  w_cnt_nxt   = '0;
                  w_led_nxt   = 1'b1;
                end
              end
              OS_ACTIVE: begin
                if (trig[i]) begin
                  w_cnt_nxt = '0;
                end else if (r_tick) begin
                  if (w_at_end) begin
                    w_state_nxt = OS_IDLE;
                    w_cnt_nxt   = '0;
                    w_led_nxt   = 1'b0;
                  end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                  end
                end
              end
              default: begin
                w_state_nxt = OS_IDLE;
              end
            endcase
          end
        end
      endcase
    end

    assign led[i]  = r_led;
    assign busy[i] = (r_state == OS_ACTIVE);
  end

endmodule

`default_nettype wire

// File: tb/tb_led_blinker_bank.sv
// ============================================================================
// Module   : tb_led_blinker_bank
// Brief    : Randomised and directed bench for led_blinker_bank vs a tick-count model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_blinker_bank;

  localparam int NCH = 4;
  localparam int TD  = 4;
  localparam int CW  = 16;

  logic                sys_clk;
  logic                sys_rst;
  logic [2*NCH-1:0]    mode;
  logic [CW*NCH-1:0]   half_period;
  logic [NCH-1:0]      trig;
  logic [NCH-1:0]      led;
  logic [NCH-1:0]      busy;
  logic                tick;

  led_blinker_bank #(
    .NCH      (NCH),
    .TICK_DIV (TD),
    .CNT_W    (CW)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .mode        (mode),
    .half_period (half_period),
    .trig        (trig),
    .led         (led),
    .busy        (busy),
    .tick        (tick)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: cycles since reset, and ticks elapsed in each channel's level/pulse.
  int             m_cyc;
  logic           m_tick;
  logic [NCH-1:0] m_led;
  logic [NCH-1:0] m_busy;
  int             m_el [NCH];
  logic [1:0]     m_prev [NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
  endtask

  task automatic model_step();
    logic       old_tick;
    logic [1:0] md;
    int         hp;
    logic       entry;
    old_tick = m_tick;
    if (sys_rst) begin
      m_cyc  = 0;
      m_tick = 1'b0;
      m_led  = '0;
      m_busy = '0;
      for (int i = 0; i < NCH; i++) begin
        m_el[i]   = 0;
        m_prev[i] = 2'b00;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        md    = mode[2*i +: 2];
        hp    = int'(half_period[CW*i +: CW]);
        if (hp == 0) hp = 1;
        entry = (md != m_prev[i]);
        case (md)
          2'b00, 2'b01: begin
            m_led[i]  = (md == 2'b01);
            m_busy[i] = 1'b0;
            m_el[i]   = 0;
          end
          2'b10: begin
            m_busy[i] = 1'b0;
            if (entry) begin
              m_led[i] = 1'b1;
              m_el[i]  = 0;
            end else if (old_tick) begin
              m_el[i]++;
              if (m_el[i] >= hp) begin
                m_led[i] = ~m_led[i];
                m_el[i]  = 0;
              end
            end
          end
          default: begin
            if (entry) begin
              m_led[i]  = 1'b0;
              m_busy[i] = 1'b0;
              m_el[i]   = 0;
            end else if (trig[i]) begin
              m_led[i]  = 1'b1;
              m_busy[i] = 1'b1;
              m_el[i]   = 0;
            end else if (m_busy[i] && old_tick) begin
              m_el[i]++;
              if (m_el[i] >= hp) begin
                m_led[i]  = 1'b0;
                m_busy[i] = 1'b0;
                m_el[i]   = 0;
              end
            end
          end
        endcase
        m_prev[i] = md;
      end
      m_cyc++;
      m_tick = ((m_cyc % TD) == 0);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_step();
    #1;
    chk("led", {28'd0, led}, {28'd0, m_led});
    chk("busy", {28'd0, busy}, {28'd0, m_busy});
    chk("tick", {31'd0, tick}, {31'd0, m_tick});
  endtask

  task automatic pulse_trig(input int ch);
    trig[ch] = 1'b1;
    step();
    trig[ch] = 1'b0;
  endtask

  initial begin
    int ch;
    sys_rst     = 1'b1;
    mode        = '0;
    half_period = '0;
    trig        = '0;
    repeat (3) step();
    sys_rst = 1'b0;
    repeat (12) step();

    half_period[0 +: CW] = 16'd3;
    mode[1:0] = 2'b10;
    repeat (130) step();

    mode[3:2] = 2'b01;
    repeat (5) step();
    mode[3:2] = 2'b00;
    repeat (5) step();
    half_period[CW +: CW] = 16'd0;
    mode[3:2] = 2'b10;
    repeat (20) step();

    half_period[2*CW +: CW] = 16'd5;
    mode[5:4] = 2'b11;
    repeat (3) step();
    pulse_trig(2);
    repeat (30) step();
    pulse_trig(2);
    repeat (12) step();
    pulse_trig(2);
    repeat (30) step();
    mode[5:4] = 2'b00;
    step();
    mode[5:4] = 2'b11;
    trig[2]   = 1'b1;
    step();
    trig[2]   = 1'b0;
    repeat (5) step();

    half_period[3*CW +: CW] = 16'd200;
    mode[7:6] = 2'b10;
    for (int k = 0; k < 1000 && m_el[3] != 150; k++) step();
    chk("ch3_reach150", m_el[3], 32'd150);
    half_period[3*CW +: CW] = 16'd10;
    repeat (60) step();

    pulse_trig(2);
    repeat (6) step();
    sys_rst = 1'b1;
    repeat (2) step();
    sys_rst = 1'b0;
    repeat (40) step();

    for (int n = 0; n < 3000; n++) begin
      sys_rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 29) == 0) begin
        ch = $urandom_range(0, NCH - 1);
        mode[2*ch +: 2] = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 49) == 0) begin
        ch = $urandom_range(0, NCH - 1);
        half_period[CW*ch +: CW] = 16'($urandom_range(0, 6));
      end
      for (int c = 0; c < NCH; c++) trig[c] = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_blinker_bank.md
Name: led_blinker_bank

Overview:
- Parametrised bank of NCH independent LED indicator channels, clocked from one system clock.
- Generalises the single fixed-rate board blinkers with per-channel mode: OFF, ON, BLINK, ONESHOT.
- Each channel has a runtime-programmable half-period in ticks; one shared prescaler generates the ticks.
- Sits in Top between status/debug sources and the LED[] outputs.

Parameters:
- NCH, 4, number of channels.
- TICK_DIV, 100000, sys_clk cycles per tick (1 ms at 100 MHz); must be >= 2. Simulation uses 4.
- CNT_W, 16, width of each half-period value and each channel counter.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- mode  in  2*NCH  per-channel mode; channel i uses bits [2i+1:2i]. 00 OFF, 01 ON, 10 BLINK, 11 ONESHOT.
- half_period  in  CNT_W*NCH  per-channel half-period in ticks; channel i uses bits [CNT_W*i +: CNT_W].
- trig  in  NCH  per-channel one-cycle trigger; used in ONESHOT only.
- led  out  NCH  registered LED drive.
- busy  out  NCH  1 while a ONESHOT pulse is active.
- tick  out  1  one-cycle prescaler strobe.

Behaviour:
- Reset (sys_rst=1 at a sys_clk edge):
  - Clears led, busy, tick, prescaler count, all channel counters.
  - Clears the per-channel registered mode copy (prev_mode) to OFF.
  - All outputs read 0 in the cycle after the reset edge.
  - Reset mid-operation aborts any blink or pulse; no state survives.
- Prescaler:
  - pcnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick is registered: it is 1 for exactly the cycle after pcnt==TICK_DIV-1 is seen.
  - Resulting period: exactly TICK_DIV cycles.
- Effective half-period: hp = max(half_period_i, 1). A value of 0 behaves as 1.
- Mode-change detect:
  - mode_i != prev_mode_i at an edge is an entry; prev_mode_i updates every cycle.
  - Entry clears cnt_i. The new mode's entry value appears on led one cycle later.
- OFF: led=0, busy=0, counter held at 0.
- ON: led=1, busy=0, counter held at 0.
- BLINK:
  - Entry sets led=1.
  - On each tick: if cnt_i >= hp-1 then cnt_i<=0 and led toggles; else cnt_i<=cnt_i+1.
  - Each level therefore lasts exactly hp ticks; there is no extra-tick off-by-one.
  - Use >= so that lowering half_period mid-count wraps on the next tick instead of counting through 2^CNT_W.
  - New half_period takes effect without restarting the phase.
- ONESHOT, per-channel FSM IDLE/ACTIVE:
  - Entry goes to IDLE with led=0, busy=0.
  - IDLE: trig_i=1 -> ACTIVE next cycle, led=1, busy=1, cnt_i=0.
  - ACTIVE, on tick: if cnt_i >= hp-1 -> IDLE, led=0, busy=0; else cnt_i+1.
  - Pulse width: hp ticks, with the first partial tick interval included (jitter < 1 tick).
  - trig_i in ACTIVE retriggers: cnt_i<=0 and the channel stays ACTIVE.
  - trig_i in the same cycle as expiry: the retrigger wins and led stays 1.
  - trig_i in the same cycle as a mode entry is ignored.
- trig_i is ignored in OFF, ON and BLINK.
- Channels are fully independent and share only tick.
- Widths: all counters are CNT_W bits. No arithmetic overflow is possible because of the >= compare.

Test Plan (TICK_DIV=4, NCH=4):
- Reset then idle: sys_rst high 3 cycles, mode=0 -> led=0, busy=0; tick pulses every 4 cycles, first pulse 4 cycles after reset release.
- Ch0 BLINK, half_period=3 -> led[0]=1 the cycle after the mode write, toggles every 12 cycles (3 ticks); 5 full periods checked.
- Ch1 ON then OFF: mode 01 -> led[1]=1 next cycle; mode 00 -> led[1]=0 next cycle. half_period=0 in BLINK -> toggles every tick (4 cycles).
- Ch2 ONESHOT, half_period=5, single trig -> busy[2]=led[2]=1 for 5 ticks (17-20 cycles), then 0; second trig issued 3 ticks in -> pulse ends 5 ticks after the second trig.
- Ch3 BLINK half_period=200; at cnt=150 change to 10 -> toggle on the next tick; ch0 meanwhile keeps its exact period, confirming independence.
- Reset mid-pulse and mid-blink on all channels -> all outputs 0 the next cycle; after release, BLINK channels restart with led=1 (treated as entry from OFF).
